// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one imem request at a time, holds the fetched
// instruction for IF/ID, and handles branch redirects, stalls and in-flight drains.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        MemStall_in,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] PC_o,
  output logic        valid_o,
  output logic        flush_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              advance_c;
  logic              redirect_c;

  assign advance_c  = !stall_i && !MemStall_in;
  assign redirect_c = branch_i && !MemStall_in;

  // Next-state logic; redirect outranks ack capture, which outranks advance.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;

    unique case (state_q)
      IDLE: begin
        if (redirect_c) begin
          pc_d = branch_target_i;
        end else if (start_i) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_c) begin
          pc_d    = branch_target_i;
          state_d = imem_ack_i ? REQ : DRAIN;
        end else if (imem_ack_i) begin
          instr_d  = imem_data_i;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + XLEN'(4);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (redirect_c) begin
          pc_d    = branch_target_i;
          state_d = REQ;
        end else if (advance_c) begin
          valid_d = 1'b0;
          instr_d = '0;
          state_d = REQ;
        end
      end
      DRAIN: begin
        // The old request completes here; its data is dropped.
        if (redirect_c) begin
          pc_d = branch_target_i;
        end
        if (imem_ack_i) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_c) begin
      valid_d = 1'b0;
      instr_d = '0;
    end
  end

  // Request address follows PC only when (re)entering REQ, so it is frozen through DRAIN.
  always_comb begin
    req_d  = (state_d == REQ) || (state_d == DRAIN);
    addr_d = (state_d == REQ) ? pc_d : addr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign instr_o     = instr_q;
  assign PC_o        = pc_out_q;
  assign valid_o     = valid_q;
  assign flush_o     = redirect_c;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table with expected
// outputs queued at drive time, plus a wrap-around instance with RESET_PC at the top.
module tb_fetch_unit;

  typedef struct {
    logic        rst;
    logic        st;
    logic        stl;
    logic        ms;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] dat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic        e_fl;
  } vec_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, stall, mstall, branch, ack;
  logic [31:0] target, data;
  logic        req, vld, flush;
  logic [31:0] addr, instr, pc;
  logic        req2, vld2, flush2;
  logic [31:0] addr2, instr2, pc2;

  vec_t vec[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .MemStall_in(mstall),
    .branch_i(branch), .branch_target_i(target), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_data_i(data), .instr_o(instr), .PC_o(pc), .valid_o(vld),
    .flush_o(flush)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .MemStall_in(mstall),
    .branch_i(branch), .branch_target_i(target), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack), .imem_data_i(data), .instr_o(instr2), .PC_o(pc2), .valid_o(vld2),
    .flush_o(flush2)
  );

  task automatic add(input logic r, input logic s, input logic sl, input logic m,
                     input logic b, input logic [31:0] t, input logic a, input logic [31:0] d,
                     input logic eq, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ei, input logic [31:0] ep, input logic ef);
    vec_t v;
    v.rst = r; v.st = s; v.stl = sl; v.ms = m; v.br = b; v.tgt = t; v.ack = a; v.dat = d;
    v.e_req = eq; v.e_addr = ea; v.e_vld = ev; v.e_ins = ei; v.e_pc = ep; v.e_fl = ef;
    vec.push_back(v);
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e, got;
    // Columns: rst st stl ms br tgt ack dat | req addr vld instr PC_o flush
    add(1,0,0,0,0,0,0,0,                  0,32'h0,  0,32'h0,        32'h0,  0); // 0 idle
    add(1,1,0,0,0,0,0,0,                  0,32'h0,  0,32'h0,        32'h0,  0); // 1 start
    add(1,0,0,0,0,0,0,0,                  1,32'h0,  0,32'h0,        32'h0,  0); // 2
    add(1,0,0,0,0,0,1,32'h1111_1111,      1,32'h0,  0,32'h0,        32'h0,  0); // 3 ack @0
    add(1,0,0,0,0,0,0,0,                  0,32'h0,  1,32'h1111_1111,32'h0,  0); // 4 hold
    add(1,0,0,0,0,0,1,32'h2222_2222,      1,32'h4,  0,32'h0,        32'h0,  0); // 5 ack @4
    add(1,0,0,0,0,0,0,0,                  0,32'h4,  1,32'h2222_2222,32'h4,  0); // 6
    add(1,0,0,0,0,0,1,32'h0050_0093,      1,32'h8,  0,32'h0,        32'h4,  0); // 7 ack @8
    add(1,0,1,0,0,0,0,0,                  0,32'h8,  1,32'h0050_0093,32'h8,  0); // 8 stall
    add(1,0,1,0,0,0,0,0,                  0,32'h8,  1,32'h0050_0093,32'h8,  0); // 9 stall
    add(1,0,1,0,0,0,0,0,                  0,32'h8,  1,32'h0050_0093,32'h8,  0); // 10 stall
    add(1,0,0,0,0,0,0,0,                  0,32'h8,  1,32'h0050_0093,32'h8,  0); // 11 release
    add(1,0,0,0,0,0,0,0,                  1,32'hC,  0,32'h0,        32'h8,  0); // 12
    add(1,0,0,0,0,0,1,32'h3333_3333,      1,32'hC,  0,32'h0,        32'h8,  0); // 13
    add(1,0,0,0,0,0,0,0,                  0,32'hC,  1,32'h3333_3333,32'hC,  0); // 14
    add(1,0,0,0,1,32'h40,0,0,             1,32'h10, 0,32'h0,        32'hC,  1); // 15 redirect
    add(1,0,0,0,0,0,0,0,                  1,32'h10, 0,32'h0,        32'hC,  0); // 16 drain
    add(1,0,0,0,0,0,1,32'hDEAD_BEEF,      1,32'h10, 0,32'h0,        32'hC,  0); // 17 drop
    add(1,0,0,0,0,0,0,0,                  1,32'h40, 0,32'h0,        32'hC,  0); // 18
    add(1,0,0,0,0,0,1,32'h4444_4444,      1,32'h40, 0,32'h0,        32'hC,  0); // 19
    add(1,0,0,1,1,32'h80,0,0,             0,32'h40, 1,32'h4444_4444,32'h40, 0); // 20 memstall
    add(1,0,0,0,1,32'h80,0,0,             0,32'h40, 1,32'h4444_4444,32'h40, 1); // 21 taken
    add(1,0,0,0,0,0,0,0,                  1,32'h80, 0,32'h0,        32'h40, 0); // 22
    add(1,0,0,0,1,32'h100,1,32'hBAD0_BAD0,1,32'h80, 0,32'h0,        32'h40, 1); // 23 br+ack
    add(1,0,0,0,0,0,0,0,                  1,32'h100,0,32'h0,        32'h40, 0); // 24
    add(1,0,0,0,0,0,1,32'h5555_5555,      1,32'h100,0,32'h0,        32'h40, 0); // 25
    add(1,0,1,0,0,0,1,32'h6666_6666,      0,32'h100,1,32'h5555_5555,32'h100,0); // 26 stray
    add(1,0,0,0,0,0,0,0,                  0,32'h100,1,32'h5555_5555,32'h100,0); // 27
    add(1,0,0,0,1,32'h200,0,0,            1,32'h104,0,32'h0,        32'h100,1); // 28
    add(1,0,0,0,1,32'h300,0,0,            1,32'h104,0,32'h0,        32'h100,1); // 29 re-redir
    add(1,0,0,0,0,0,1,32'h7777_7777,      1,32'h104,0,32'h0,        32'h100,0); // 30
    add(0,0,0,0,0,0,0,0,                  1,32'h300,0,32'h0,        32'h100,0); // 31 reset
    add(1,0,0,0,0,0,1,32'h8888_8888,      0,32'h0,  0,32'h0,        32'h0,  0); // 32 stray
    add(1,0,0,0,0,0,0,0,                  0,32'h0,  0,32'h0,        32'h0,  0); // 33
    add(1,1,0,0,0,0,0,0,                  0,32'h0,  0,32'h0,        32'h0,  0); // 34
    add(1,0,0,0,0,0,0,0,                  1,32'h0,  0,32'h0,        32'h0,  0); // 35
    add(0,0,0,0,0,0,0,0,                  1,32'h0,  0,32'h0,        32'h0,  0); // 36 reset in REQ
    add(1,0,0,0,1,32'h50,0,0,             0,32'h0,  0,32'h0,        32'h0,  1); // 37 idle br
    add(1,1,0,0,0,0,0,0,                  0,32'h0,  0,32'h0,        32'h0,  0); // 38
    add(1,0,0,0,0,0,0,0,                  1,32'h50, 0,32'h0,        32'h0,  0); // 39

    rst = 1'b0; start = 1'b0; stall = 1'b0; mstall = 1'b0; branch = 1'b0;
    target = '0; ack = 1'b0; data = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      rst = vec[i].rst; start = vec[i].st; stall = vec[i].stl; mstall = vec[i].ms;
      branch = vec[i].br; target = vec[i].tgt; ack = vec[i].ack; data = vec[i].dat;
      e.req = vec[i].e_req; e.addr = vec[i].e_addr; e.vld = vec[i].e_vld;
      e.ins = vec[i].e_ins; e.pc = vec[i].e_pc; e.fl = vec[i].e_fl;
      sb.push_back(e);
      #1;
      got.req = req; got.addr = addr; got.vld = vld; got.ins = instr; got.pc = pc; got.fl = flush;
      e = sb.pop_front();
      n_vec++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL vec%0d: got req=%b addr=%h vld=%b instr=%h pc=%h flush=%b, expected req=%b addr=%h vld=%b instr=%h pc=%h flush=%b",
                 i, got.req, got.addr, got.vld, got.ins, got.pc, got.fl,
                 e.req, e.addr, e.vld, e.ins, e.pc, e.fl);
      end
      // Wrap-around instance runs the same stimulus from RESET_PC = 0xFFFF_FFFC.
      if (i == 2) check1("wrap_first_addr", addr2, 32'hFFFF_FFFC);
      if (i == 4) check1("wrap_pc_o", pc2, 32'hFFFF_FFFC);
      if (i == 4) check1("wrap_valid", 32'(vld2), 32'h1);
      if (i == 5) check1("wrap_next_addr", addr2, 32'h0);
      if (i == 33) check1("wrap_reset_instr", instr2, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
